idecoder_pipe: RTL and testbench

Parametrised, pipelined RV32I instruction decoder with valid/ready handshakes on both sides. It sits between instruction fetch and register-read/execute and replaces the fixed-delay request/response decoder. Each accepted instruction word and its PC are decoded into register addresses, function fields, a sign-extended immediate, a format class and register-usage flags. The block detects illegal encodings, supports 1–4 register stages with back-pressure, and has a single-cycle flush.

---
 rtl/idecoder_pipe.sv | 267 ++++++++++++++++++++++++++
 tb/tb_idecoder_pipe.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idecoder_pipe.sv
// idecoder_pipe: pipelined RV32I instruction decoder.
// Valid/ready on both sides, 1..4 register stages, single-cycle flush.
module idecoder_pipe #(
  parameter int STAGES         = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [6:0]                out_opcode,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2_addr,
  output logic [2:0]                out_funct3,
  output logic [6:0]                out_funct7,
  output logic [DATA_WIDTH-1:0]     out_imm,
  output logic [2:0]                out_fmt,
  output logic                      out_rd_we,
  output logic                      out_rs1_used,
  output logic                      out_rs2_used,
  output logic                      out_illegal
);

  localparam int DW  = DATA_WIDTH;
  localparam int RAW = REG_ADDR_WIDTH;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_R      = 7'h33;
  localparam opcode_t OP_IMM    = 7'h13;
  localparam opcode_t OP_LOAD   = 7'h03;
  localparam opcode_t OP_STORE  = 7'h23;
  localparam opcode_t OP_BRANCH = 7'h63;
  localparam opcode_t OP_JAL    = 7'h6F;
  localparam opcode_t OP_JALR   = 7'h67;
  localparam opcode_t OP_LUI    = 7'h37;
  localparam opcode_t OP_AUIPC  = 7'h17;
  localparam opcode_t OP_FENCE  = 7'h0F;
  localparam opcode_t OP_SYSTEM = 7'h73;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [DW-1:0]  pc;
    opcode_t        opcode;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [DW-1:0]  imm;
    logic [2:0]     fmt;
    logic           rd_we;
    logic           rs1_used;
    logic           rs2_used;
    logic           illegal;
  } dec_t;

  opcode_t        op;
  logic [2:0]     f3;
  logic [6:0]     f7;
  logic [RAW-1:0] rd_f;
  logic [RAW-1:0] rs1_f;
  logic [RAW-1:0] rs2_f;
  logic [DW-1:0]  imm_i;
  logic [DW-1:0]  imm_s;
  logic [DW-1:0]  imm_b;
  logic [DW-1:0]  imm_u;
  logic [DW-1:0]  imm_j;
  logic           ill;
  dec_t           dec;

  dec_t              pipe_q [STAGES];
  dec_t              pipe_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES:0]   rdy;
  logic              acc;

  // Raw field slices and all immediate forms of the incoming word
  always_comb begin
    op    = in_instr[6:0];
    f3    = in_instr[14:12];
    f7    = in_instr[31:25];
    rd_f  = RAW'(in_instr[11:7]);
    rs1_f = RAW'(in_instr[19:15]);
    rs2_f = RAW'(in_instr[24:20]);
    imm_i = DW'($signed(in_instr[31:20]));
    imm_s = DW'($signed({in_instr[31:25], in_instr[11:7]}));
    imm_b = DW'($signed({in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8],
                         1'b0}));
    imm_u = DW'($signed({in_instr[31:12], 12'b0}));
    imm_j = DW'($signed({in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21],
                         1'b0}));
  end

  // Format decode, legality check and per-format field gating
  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = op;
    ill        = (in_instr[1:0] != 2'b11);
    unique case (1'b1)
      (op == OP_R): begin
        ill = ill || !((f7 == 7'h00) ||
              ((f7 == 7'h20) &&
               ((f3 == 3'b000) || (f3 == 3'b101))));
        dec.fmt      = FMT_R;
        dec.rd       = rd_f;
        dec.rs1      = rs1_f;
        dec.rs2      = rs2_f;
        dec.funct3   = f3;
        dec.funct7   = f7;
        dec.rd_we    = (rd_f != '0);
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      (op == OP_IMM),
      (op == OP_LOAD),
      (op == OP_JALR),
      (op == OP_FENCE),
      (op == OP_SYSTEM): begin
        if (op == OP_IMM) begin
          ill = ill ||
                ((f3 == 3'b001) && (f7 != 7'h00)) ||
                ((f3 == 3'b101) && (f7 != 7'h00) &&
                 (f7 != 7'h20));
          dec.funct7 = f7;
        end
        if (op == OP_LOAD) begin
          ill = ill || (f3 == 3'b011) ||
                (f3 == 3'b110) || (f3 == 3'b111);
        end
        if (op == OP_JALR) begin
          ill = ill || (f3 != 3'b000);
        end
        dec.fmt      = FMT_I;
        dec.rd       = rd_f;
        dec.rs1      = rs1_f;
        dec.funct3   = f3;
        dec.imm      = imm_i;
        dec.rd_we    = (rd_f != '0) && (op != OP_FENCE);
        dec.rs1_used = 1'b1;
      end
      (op == OP_STORE): begin
        ill          = ill || (f3 > 3'b010);
        dec.fmt      = FMT_S;
        dec.rs1      = rs1_f;
        dec.rs2      = rs2_f;
        dec.funct3   = f3;
        dec.imm      = imm_s;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      (op == OP_BRANCH): begin
        ill = ill || (f3 == 3'b010) ||
              (f3 == 3'b011);
        dec.fmt      = FMT_B;
        dec.rs1      = rs1_f;
        dec.rs2      = rs2_f;
        dec.funct3   = f3;
        dec.imm      = imm_b;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      (op == OP_LUI),
      (op == OP_AUIPC): begin
        dec.fmt   = FMT_U;
        dec.rd    = rd_f;
        dec.imm   = imm_u;
        dec.rd_we = (rd_f != '0);
      end
      (op == OP_JAL): begin
        dec.fmt   = FMT_J;
        dec.rd    = rd_f;
        dec.imm   = imm_j;
        dec.rd_we = (rd_f != '0);
      end
      default: begin
        ill = 1'b1;
      end
    endcase
    // Illegal words keep only PC and raw opcode
    if (ill) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.opcode  = op;
      dec.fmt     = FMT_ILL;
      dec.illegal = 1'b1;
    end
  end

  // Ready chain from the output back to stage 1, next-state of each stage
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !vld_q[k] || rdy[k+1];
    end
    in_ready = rdy[0] && !flush;
    acc      = in_valid && in_ready;
    vld_d    = vld_q;
    pipe_d   = pipe_q;
    if (rdy[0]) begin
      vld_d[0] = acc;
      if (acc) begin
        pipe_d[0] = dec;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (rdy[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          pipe_d[k] = pipe_q[k-1];
        end
      end
    end
    if (flush) begin
      vld_d = '0;
    end
  end

  // Stage registers; reset clears valids and payload
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      pipe_q <= pipe_d;
    end
  end

  assign out_valid    = vld_q[STAGES-1];
  assign out_pc       = pipe_q[STAGES-1].pc;
  assign out_opcode   = pipe_q[STAGES-1].opcode;
  assign out_rd_addr  = pipe_q[STAGES-1].rd;
  assign out_rs1_addr = pipe_q[STAGES-1].rs1;
  assign out_rs2_addr = pipe_q[STAGES-1].rs2;
  assign out_funct3   = pipe_q[STAGES-1].funct3;
  assign out_funct7   = pipe_q[STAGES-1].funct7;
  assign out_imm      = pipe_q[STAGES-1].imm;
  assign out_fmt      = pipe_q[STAGES-1].fmt;
  assign out_rd_we    = pipe_q[STAGES-1].rd_we;
  assign out_rs1_used = pipe_q[STAGES-1].rs1_used;
  assign out_rs2_used = pipe_q[STAGES-1].rs2_used;
  assign out_illegal  = pipe_q[STAGES-1].illegal;

endmodule

// File: tb/tb_idecoder_pipe.sv
// tb_idecoder_pipe: scoreboard bench for idecoder_pipe.
// Three instances (STAGES 1, 2, 4) share stimulus; sel picks the active one.
module tb_idecoder_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        we;
    logic        u1;
    logic        u2;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [1:0]  sel;

  exp_t obs [3];
  logic ovld [3];
  logic irdy [3];
  exp_t obs_s;
  logic ov_s;
  logic ir_s;

  exp_t sb [$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        we;
    logic        u1;
    logic        u2;
    logic        ill;
    logic        ov;
    logic        ir;
    idecoder_pipe #(.STAGES(S)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid && (sel == 2'(g))),
      .in_ready     (ir),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .out_valid    (ov),
      .out_ready    (out_ready),
      .out_pc       (pc),
      .out_opcode   (op),
      .out_rd_addr  (rd),
      .out_rs1_addr (rs1),
      .out_rs2_addr (rs2),
      .out_funct3   (f3),
      .out_funct7   (f7),
      .out_imm      (imm),
      .out_fmt      (fmt),
      .out_rd_we    (we),
      .out_rs1_used (u1),
      .out_rs2_used (u2),
      .out_illegal  (ill)
    );
    assign obs[g]  = {pc, op, rd, rs1, rs2, f3, f7,
                      imm, fmt, we, u1, u2, ill};
    assign ovld[g] = ov;
    assign irdy[g] = ir;
  end

  always_comb begin
    obs_s = obs[0];
    ov_s  = ovld[0];
    ir_s  = irdy[0];
    case (sel)
      2'd1: begin
        obs_s = obs[1];
        ov_s  = ovld[1];
        ir_s  = irdy[1];
      end
      2'd2: begin
        obs_s = obs[2];
        ov_s  = ovld[2];
        ir_s  = irdy[2];
      end
      default: ;
    endcase
  end

  function automatic exp_t mk(
    input logic [31:0] pc, input logic [6:0] op,
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] imm,
    input logic [2:0] fmt, input logic we,
    input logic u1, input logic u2, input logic ill);
    return '{pc, op, rd, rs1, rs2, f3, f7, imm,
             fmt, we, u1, u2, ill};
  endfunction

  // Reference decoder used for the random sweep
  function automatic exp_t model(input logic [31:0] i,
                                 input logic [31:0] pc);
    exp_t e;
    logic bad;
    logic [2:0] f3;
    logic [6:0] f7;
    f3  = i[14:12];
    f7  = i[31:25];
    e   = '0;
    bad = 1'b0;
    e.pc = pc;
    e.opcode = i[6:0];
    case (i[6:0])
      7'h33: begin
        bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        e.fmt = 0; e.rd = i[11:7]; e.rs1 = i[19:15];
        e.rs2 = i[24:20]; e.f3 = f3; e.f7 = f7;
        e.we = (i[11:7] != 0); e.u1 = 1; e.u2 = 1;
      end
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
        if (i[6:0] == 7'h13) begin
          bad = (f3 == 1 && f7 != 0) ||
                (f3 == 5 && f7 != 0 && f7 != 7'h20);
          e.f7 = f7;
        end
        if (i[6:0] == 7'h03) bad = (f3 == 3 || f3 == 6 || f3 == 7);
        if (i[6:0] == 7'h67) bad = (f3 != 0);
        e.fmt = 1; e.rd = i[11:7]; e.rs1 = i[19:15]; e.f3 = f3;
        e.imm = {{20{i[31]}}, i[31:20]};
        e.we = (i[11:7] != 0) && (i[6:0] != 7'h0F); e.u1 = 1;
      end
      7'h23: begin
        bad = (f3 > 2);
        e.fmt = 2; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = f3;
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        e.u1 = 1; e.u2 = 1;
      end
      7'h63: begin
        bad = (f3 == 2 || f3 == 3);
        e.fmt = 3; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = f3;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.u1 = 1; e.u2 = 1;
      end
      7'h37, 7'h17: begin
        e.fmt = 4; e.rd = i[11:7]; e.imm = {i[31:12], 12'h000};
        e.we = (i[11:7] != 0);
      end
      7'h6F: begin
        e.fmt = 5; e.rd = i[11:7];
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        e.we = (i[11:7] != 0);
      end
      default: bad = 1'b1;
    endcase
    if (bad) e = mk(pc, i[6:0], 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1);
    return e;
  endfunction

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return 7'h33;  1: return 7'h13;  2: return 7'h03;
      3: return 7'h23;  4: return 7'h63;  5: return 7'h6F;
      6: return 7'h67;  7: return 7'h37;  8: return 7'h17;
      9: return 7'h0F; 10: return 7'h73; 11: return 7'h0B;
      12: return 7'h7F;
      default: return 7'h12;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the word until accepted; record expectation on acceptance
  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input exp_t e, input bit rnd);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    forever begin
      if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (ir_s && !rst) begin
        sb.push_back(e);
        break;
      end
      w++;
      if (w > 60) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout pc=%h: got no in_ready, expected accept", pc);
        break;
      end
      step();
    end
    step();
  endtask

  task automatic drain();
    int w;
    w = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && w < 60) begin
      step();
      w++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops and compares on every output handshake
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (ov_s && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_out: got pc=%h, expected no output", obs_s.pc);
        end else begin
          mon_e = sb.pop_front();
          if (obs_s !== mon_e) begin
            n_fail++;
            $display("FAIL dec_out pc=%h: got %h expected %h",
                     mon_e.pc, obs_s, mon_e);
          end
        end
      end
      if (flush) sb.delete();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_pc = '0; out_ready = 1'b1; sel = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(ov_s), 32'd0);
    chk("reset_in_ready", 32'(ir_s), 32'd1);
    chk("reset_out_pc", obs_s.pc, 32'd0);
    chk("reset_out_imm", obs_s.imm, 32'd0);
    step();

    // ADDI with latency check at STAGES=2
    send(32'hFFB10093, 32'h100,
         mk(32'h100, 7'h13, 1, 2, 0, 0, 7'h7F, 32'hFFFFFFFB,
            1, 1, 1, 0, 0), 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi_lat_early", 32'(ov_s), 32'd0);
    step();
    @(negedge clk);
    chk("addi_lat_due", 32'(ov_s), 32'd1);
    step();

    // Branch and jump immediates
    send(32'h00208863, 32'h104,
         mk(32'h104, 7'h63, 0, 1, 2, 0, 0, 32'h10, 3, 0, 1, 1, 0), 0);
    send(32'hFF9FF0EF, 32'h108,
         mk(32'h108, 7'h6F, 1, 0, 0, 0, 0, 32'hFFFFFFF8,
            5, 1, 0, 0, 0), 0);
    // Illegal encodings
    send(32'h00000000, 32'h10C,
         mk(32'h10C, 7'h00, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1), 0);
    send(32'h40001033, 32'h110,
         mk(32'h110, 7'h33, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1), 0);
    drain();

    // Back-pressure: two fill, third waits, push and pop together
    out_ready = 1'b0;
    send(32'h002081B3, 32'h200,
         mk(32'h200, 7'h33, 3, 1, 2, 0, 0, 0, 0, 1, 1, 1, 0), 0);
    send(32'h407302B3, 32'h204,
         mk(32'h204, 7'h33, 5, 6, 7, 0, 7'h20, 0, 0, 1, 1, 1, 0), 0);
    in_instr = 32'h12345537;
    in_pc    = 32'h208;
    @(negedge clk);
    chk("bp_full_in_ready", 32'(ir_s), 32'd0);
    chk("bp_stall_valid", 32'(ov_s), 32'd1);
    chk("bp_stall_pc", obs_s.pc, 32'h200);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_push_pop_ready", 32'(ir_s), 32'd1);
    if (ir_s)
      sb.push_back(mk(32'h208, 7'h37, 10, 0, 0, 0, 0, 32'h12345000,
                      4, 1, 0, 0, 0));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_consec_valid", 32'(ov_s), 32'd1);
    drain();

    // Flush with two in flight and an offered input
    out_ready = 1'b0;
    send(32'h0020A423, 32'h300,
         mk(32'h300, 7'h23, 0, 1, 2, 2, 0, 32'h8, 2, 0, 1, 1, 0), 0);
    send(32'hFFC1A203, 32'h304,
         mk(32'h304, 7'h03, 4, 3, 0, 2, 0, 32'hFFFFFFFC,
            1, 1, 1, 0, 0), 0);
    in_instr = 32'h0FF0000F;
    in_pc    = 32'h308;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(ir_s), 32'd0);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 32'(ov_s), 32'd0);
    step();
    send(32'h00000013, 32'h30C,
         mk(32'h30C, 7'h13, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), 0);
    send(32'h0FF0000F, 32'h310,
         mk(32'h310, 7'h0F, 0, 0, 0, 0, 0, 32'hFF, 1, 0, 1, 0, 0), 0);
    drain();

    // Reset mid-stream
    out_ready = 1'b0;
    send(32'h0020A423, 32'h400,
         mk(32'h400, 7'h23, 0, 1, 2, 2, 0, 32'h8, 2, 0, 1, 1, 0), 0);
    send(32'h002081B3, 32'h404,
         mk(32'h404, 7'h33, 3, 1, 2, 0, 0, 0, 0, 1, 1, 1, 0), 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(ov_s), 32'd0);
    chk("rst_mid_pc", obs_s.pc, 32'd0);
    chk("rst_mid_any_field", 32'(|obs_s), 32'd0);
    step();
    drain();

    // Random legal/illegal sweep at STAGES=1 then STAGES=4
    for (int ph = 0; ph < 2; ph++) begin
      sel = (ph == 0) ? 2'd0 : 2'd2;
      step();
      for (int n = 0; n < 150; n++) begin
        ins = $urandom;
        ins[6:0] = pick_op($urandom_range(0, 13));
        if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) &&
            $urandom_range(0, 2) != 0)
          ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 3) == 0) begin
          in_valid  = 1'b0;
          out_ready = ($urandom_range(0, 2) != 0);
          step();
        end
        send(ins, 32'h1000 + 32'(n * 4),
             model(ins, 32'h1000 + 32'(n * 4)), 1);
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
